// File: rtl/cmos_pkg.sv
// ---------------------------------------------------------------------------
// cmos_pkg
// Shared encodings for the CMOS camera capture slice:
//   mode_e  - pixel format selector latched at frame start
//   state_e - capture FSM state (wait for first frame, skip settling frames,
//             deliver pixels)
// ---------------------------------------------------------------------------
package cmos_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RAW8   = 2'd1
  } mode_e;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Reserved mode codes (2, 3) fall back to RGB565.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    return (raw == 2'd1) ? MODE_RAW8 : MODE_RGB565;
  endfunction

endpackage

// File: rtl/cmos_pix_unpack.sv
// ---------------------------------------------------------------------------
// cmos_pix_unpack
// Combinational pixel-format expansion to 24-bit RGB.
//   byte_hi : first byte of an RGB565 pair (D[15:8]); unused in RAW8
//   byte_lo : second RGB565 byte (D[7:0]) or the RAW8 luma byte
//   mode    : pixel format
//   rgb24   : {R8, G8, B8}
// RGB565 channels are widened by replicating their MSBs into the new LSBs,
// so full-scale inputs map to 0xFF and zero stays zero.
// ---------------------------------------------------------------------------
module cmos_pix_unpack
  import cmos_pkg::*;
(
  input  logic [7:0]  byte_hi,
  input  logic [7:0]  byte_lo,
  input  mode_e       mode,
  output logic [23:0] rgb24
);

  logic [15:0] word;
  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;

  assign word = {byte_hi, byte_lo};
  assign r5   = word[15:11];
  assign g6   = word[10:5];
  assign b5   = word[4:0];

  always_comb begin
    if (mode == MODE_RAW8) begin
      rgb24 = {byte_lo, byte_lo, byte_lo};
    end else begin
      rgb24 = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    end
  end

endmodule

// File: rtl/cmos_capture_ml.sv
// ---------------------------------------------------------------------------
// cmos_capture_ml
// Captures a DVP-style CMOS sensor stream and delivers 24-bit RGB pixels.
// Parameters:
//   DATA_W      - sensor bus width (8 or 10; the upper 8 bits are used)
//   CNT_W       - width of the x/y coordinate counters
//   SKIP_FRAMES - whole frames discarded after reset while the sensor settles
// Ports:
//   CLK_i, rst_i          - clock, synchronous active-high reset
//   cmos_ce_i             - byte qualifier for the sensor inputs
//   cmos_vsync_i/href_i   - frame sync / line valid
//   cmos_data_i           - sensor byte
//   mode_i                - 0 RGB565, 1 RAW8, others RGB565 (latched per frame)
//   crop_en_i, crop_*_i   - inclusive crop window (latched per frame)
//   rgb_o, de_o           - pixel and its one-cycle valid
//   hs_o, vs_o            - href / vsync aligned with de_o
//   x_o, y_o              - sensor coordinates of rgb_o
//   frame_cnt_o           - delivered-frame counter (wraps)
//   line_err_o            - sticky: a line ended on half an RGB565 pixel
// Pipeline: S1 registers the sensor inputs on ce; the output stage decodes
// S1 (edges, byte phase, counters) and registers the pixel. de_o therefore
// rises two cycles after the ce cycle carrying the completing byte.
// ---------------------------------------------------------------------------
module cmos_capture_ml
  import cmos_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 12,
  parameter int SKIP_FRAMES = 10
) (
  input  logic              CLK_i,
  input  logic              rst_i,
  input  logic              cmos_ce_i,
  input  logic              cmos_vsync_i,
  input  logic              cmos_href_i,
  input  logic [DATA_W-1:0] cmos_data_i,
  input  logic [1:0]        mode_i,
  input  logic              crop_en_i,
  input  logic [CNT_W-1:0]  crop_x0_i,
  input  logic [CNT_W-1:0]  crop_x1_i,
  input  logic [CNT_W-1:0]  crop_y0_i,
  input  logic [CNT_W-1:0]  crop_y1_i,
  output logic [23:0]       rgb_o,
  output logic              de_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic [CNT_W-1:0]  x_o,
  output logic [CNT_W-1:0]  y_o,
  output logic [15:0]       frame_cnt_o,
  output logic              line_err_o
);

  localparam int SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------- S1: sensor input register ----------------
  logic       s1_vld;   // S1 was loaded in the previous cycle
  logic       s1_vs, s1_hs;
  logic       s1_vs_d, s1_hs_d; // S1 values from the previous ce cycle
  logic [7:0] s1_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs_d <= 1'b0;
      s1_hs_d <= 1'b0;
      s1_data <= 8'h00;
    end else begin
      s1_vld <= cmos_ce_i;
      if (cmos_ce_i) begin
        s1_vs_d <= s1_vs;
        s1_hs_d <= s1_hs;
        s1_vs   <= cmos_vsync_i;
        s1_hs   <= cmos_href_i;
        s1_data <= cmos_data_i[DATA_W-1 -: 8];
      end
    end
  end

  logic frame_start, line_end;
  assign frame_start = s1_vld && s1_vs && !s1_vs_d;
  assign line_end    = s1_vld && !s1_hs && s1_hs_d;

  // ---------------- FSM ----------------
  state_e            state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt;

  always_ff @(posedge CLK_i) begin
    if (rst_i) state <= ST_WAIT;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: if (frame_start) state_nxt = (SKIP_FRAMES == 0) ? ST_RUN : ST_SKIP;
      ST_SKIP: if (frame_start && skip_cnt == SKIP_W'(SKIP_FRAMES)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_WAIT;
    endcase
  end

  // Counts frame starts since leaving WAIT; the first one is counted on entry.
  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      skip_cnt <= '0;
    end else if (frame_start) begin
      if (state == ST_WAIT)                               skip_cnt <= SKIP_W'(1);
      else if (state == ST_SKIP && state_nxt == ST_SKIP)  skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end

  // ---------------- per-frame configuration ----------------
  mode_e            mode_q;
  logic             crop_en_q;
  logic [CNT_W-1:0] crop_x0_q, crop_x1_q, crop_y0_q, crop_y1_q;

  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      mode_q    <= MODE_RGB565;
      crop_en_q <= 1'b0;
      crop_x0_q <= '0;
      crop_x1_q <= '0;
      crop_y0_q <= '0;
      crop_y1_q <= '0;
    end else if (frame_start) begin
      mode_q    <= decode_mode(mode_i);
      crop_en_q <= crop_en_i;
      crop_x0_q <= crop_x0_i;
      crop_x1_q <= crop_x1_i;
      crop_y0_q <= crop_y0_i;
      crop_y1_q <= crop_y1_i;
    end
  end

  // ---------------- pixel assembly and output stage ----------------
  logic             phase;    // 1: holding the first RGB565 byte
  logic [7:0]       byte_hi;
  logic [CNT_W-1:0] x_cnt, y_cnt; // coordinates of the next pixel
  logic [23:0]      pix_rgb;
  logic             crop_ok;

  cmos_pix_unpack u_unpack (
    .byte_hi (byte_hi),
    .byte_lo (s1_data),
    .mode    (mode_q),
    .rgb24   (pix_rgb)
  );

  // An inverted window (x0 > x1 or y0 > y1) can never satisfy both bounds.
  assign crop_ok = !crop_en_q ||
                   ((x_cnt >= crop_x0_q) && (x_cnt <= crop_x1_q) &&
                    (y_cnt >= crop_y0_q) && (y_cnt <= crop_y1_q));

  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      phase       <= 1'b0;
      byte_hi     <= 8'h00;
      x_cnt       <= '0;
      y_cnt       <= '0;
      rgb_o       <= 24'h0;
      de_o        <= 1'b0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      frame_cnt_o <= 16'h0;
      line_err_o  <= 1'b0;
    end else begin
      de_o <= 1'b0;
      hs_o <= s1_hs;
      vs_o <= s1_vs;
      if (frame_start) begin
        // Also aborts a line in progress: the held byte is dropped silently.
        phase <= 1'b0;
        x_cnt <= '0;
        y_cnt <= '0;
        if (state_nxt == ST_RUN) frame_cnt_o <= frame_cnt_o + 16'd1;
      end else if (s1_vld) begin
        if (!s1_hs) begin
          phase <= 1'b0;
          if (line_end) begin
            x_cnt <= '0;
            y_cnt <= sat_inc(y_cnt);
            if (phase) line_err_o <= 1'b1;
          end
        end else if (mode_q == MODE_RGB565 && !phase) begin
          byte_hi <= s1_data;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          rgb_o <= pix_rgb;
          x_o   <= x_cnt;
          y_o   <= y_cnt;
          x_cnt <= sat_inc(x_cnt);
          de_o  <= (state == ST_RUN) && crop_ok;
        end
      end
    end
  end

endmodule

// File: doc/cmos_capture_ml.md
CMOS_CAPTURE_ML -- requirements
Module: cmos_capture_ml

Interface
REQ-001 Parameter DATA_W, default 8: sensor data bus width; only 8 and 10 are legal, and for 10 the upper 8 bits are used.
REQ-002 Parameter CNT_W, default 12: width of the pixel and line counters.
REQ-003 Parameter SKIP_FRAMES, default 10: number of whole frames discarded after reset while the sensor settles.
REQ-004 CLK_i  input  1: the single clock; all logic is on its rising edge.
REQ-005 rst_i  input  1: reset, synchronous and active-high.
REQ-006 cmos_ce_i  input  1: byte qualifier; sensor inputs are sampled only in cycles where it is 1.
REQ-007 cmos_vsync_i  input  1: frame sync, active-high.
REQ-008 cmos_href_i  input  1: line valid.
REQ-009 cmos_data_i  input  DATA_W: sensor byte.
REQ-010 mode_i  input  2: pixel format; 0 = RGB565, 1 = RAW8 mono, 2–3 reserved (treated as 0).
REQ-011 crop_en_i  input  1: enables the crop window.
REQ-012 crop_x0_i, crop_x1_i, crop_y0_i, crop_y1_i  input  CNT_W each: inclusive crop window bounds.
REQ-013 rgb_o  output  24: output pixel, {R8,G8,B8}.
REQ-014 de_o  output  1: rgb_o valid.
REQ-015 hs_o  output  1: line active (delayed href).
REQ-016 vs_o  output  1: frame sync (delayed vsync).
REQ-017 x_o, y_o  output  CNT_W each: coordinates of the current rgb_o pixel.
REQ-018 frame_cnt_o  output  16: count of delivered frames.
REQ-019 line_err_o  output  1: sticky flag for a partial pixel at line end.

Function
REQ-020 The block shall register cmos_vsync_i, cmos_href_i and cmos_data_i in every cycle where cmos_ce_i=1 (stage S1).
REQ-021 Frame start shall be the S1 vsync rising edge; line end shall be the S1 href falling edge.
REQ-022 The FSM shall have three states: WAIT (waiting for the first frame start), SKIP (discarding SKIP_FRAMES frames), RUN (delivering pixels).
REQ-023 FSM transitions: WAIT→SKIP on frame start; SKIP→RUN on the frame start after SKIP_FRAMES starts have been counted; RUN stays in RUN.
REQ-024 If SKIP_FRAMES=0, WAIT shall go directly to RUN.
REQ-025 mode_i and all crop inputs shall be latched at frame start and held constant for that frame.
REQ-026 RGB565: a byte phase bit shall toggle on each href-valid byte and clear when href is low.
REQ-027 RGB565 byte order: first byte = D[15:8], second byte = D[7:0]; the pixel completes on the second byte.
REQ-028 RGB565 expansion shall use MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-029 RAW8: every href-valid byte shall be one pixel, output as rgb_o={Y,Y,Y}.
REQ-030 de_o shall assert exactly 2 CLK_i cycles after the ce cycle that carries the completing byte, for one cycle, and only when the FSM is in RUN.
REQ-031 x shall increment per completed pixel and reset to 0 at line end.
REQ-032 y shall increment at each line end and reset to 0 at frame start.
REQ-033 x and y shall saturate at 2^CNT_W−1, with no wrap.
REQ-034 With crop_en=1, de_o shall be suppressed unless x0≤x≤x1 and y0≤y≤y1.
REQ-035 A crop window with x0>x1 or y0>y1 shall suppress every pixel.
REQ-036 x_o and y_o shall be the unadjusted sensor coordinates.
REQ-037 If href falls with the RGB565 phase at 1, the partial byte shall be dropped and line_err_o set; line_err_o is sticky until reset.
REQ-038 Frame start during an active line shall abort the line: the phase clears, x/y clear, and no pixel is emitted from the held byte.
REQ-039 frame_cnt_o shall increment on each frame start seen in RUN and wrap from 0xFFFF to 0.
REQ-040 hs_o and vs_o shall be the S1 href/vsync delayed to align with de_o (total latency 2 cycles).

Reset
REQ-041 On rst_i=1: FSM=WAIT; rgb_o=0, de_o=0, hs_o=0, vs_o=0, x_o=0, y_o=0, frame_cnt_o=0, line_err_o=0; skip counter, phase bit and the latched mode/crop registers cleared.
REQ-042 Reset asserted mid-line shall discard the in-flight pixel, with de_o low on the following cycle.

Structure
REQ-043 A shared package cmos_pkg shall hold the mode encodings (MODE_RGB565=0, MODE_RAW8=1) and the FSM state encoding.
REQ-044 Format unpacking and expansion shall be one sub-module, cmos_pix_unpack, which is combinational from {byte_hi, byte_lo, mode} to rgb24.

Verification
REQ-045 SKIP_FRAMES=2: 4 frames of 4×2 RGB565 -> no de_o in frames 1–2; 8 de_o pulses in each of frames 3 and 4; frame_cnt_o=2 at the end.
REQ-046 RGB565 bytes 0xF8,0x00 -> rgb_o=0xFF0000; bytes 0x07,0xE0 -> rgb_o=0x00FF00; de_o 2 cycles after the second byte.
REQ-047 RAW8 mode, byte 0x5A -> rgb_o=0x5A5A5A with de_o per byte; x_o runs 0..N−1.
REQ-048 Crop x0=1, x1=2, y0=1, y1=1 on a 4×3 frame -> exactly 2 de_o pulses, at (1,1) and (2,1).
REQ-049 Line of 3 RGB565 bytes -> 1 pixel output, line_err_o=1 and it stays 1 across the next frame.
REQ-050 rst_i for 1 cycle mid-line in RUN -> all outputs 0 next cycle; FSM returns to WAIT and re-skips SKIP_FRAMES frames.
